// File: rtl/d_flip_flop.sv
// d_flip_flop
//   Edge-triggered D-type register with synchronous, active-high reset.
//   It can also be cascaded into a short fixed-latency delay line.
//   The default is one bit wide and one stage deep.
//
// Parameters
//   WIDTH        data width in bits (1..64)
//   STAGES       number of cascaded stages, equal to the latency in cycles (1..16)
//   RESET_VALUE  value loaded into every stage on reset; bits above WIDTH are ignored
//
// Ports (positional order q, rst, clk, d)
//   q    out  WIDTH  value held in the last stage
//   rst  in   1      synchronous reset, active high, sampled on the rising edge of clk
//   clk  in   1      rising-edge clock
//   d    in   WIDTH  data input, sampled on the rising edge of clk
module d_flip_flop #(
  parameter int          WIDTH       = 1,
  parameter int          STAGES      = 1,
  parameter logic [63:0] RESET_VALUE = 64'd0
) (
  output logic [WIDTH-1:0] q,
  input  logic             rst,
  input  logic             clk,
  input  logic [WIDTH-1:0] d
);

  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

  // pipe[0] is the input tap.
  // pipe[i] for i >= 1 is the output of stage i-1.
  logic [STAGES:0][WIDTH-1:0] pipe;

  assign pipe[0] = d;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    // No enable on any stage.
    // Reset clears every stage at once, so no data in flight survives a reset.
    always_ff @(posedge clk) begin
      if (rst) pipe[g+1] <= RST_V;
      else     pipe[g+1] <= pipe[g];
    end
  end

  assign q = pipe[STAGES];

endmodule

// File: tb/tb_d_flip_flop.sv
module tb_d_flip_flop;
  logic       clk = 1'b0;
  logic       rst1 = 1'b0;
  logic       d1 = 1'b0;
  logic       q1;
  logic       rst8 = 1'b1;
  logic [7:0] d8 = 8'h00;
  logic [7:0] q8;

  always #5 clk = ~clk;

  d_flip_flop u_def (.q(q1), .rst(rst1), .clk(clk), .d(d1));

  d_flip_flop #(.WIDTH(8), .STAGES(3), .RESET_VALUE(64'hFFFF_FFA5)) u_par (
    .q(q8), .rst(rst8), .clk(clk), .d(d8));

  int tests = 0;
  int fails = 0;
  int known1 = 0;
  int known8 = 0;

  typedef struct {
    logic       known;
    logic [7:0] val;
  } exp_t;

  // Per-edge record of what was sampled: {rst, d}.
  logic [8:0] h1[$];
  logic [8:0] h8[$];
  exp_t       sb1[$];
  exp_t       sb8[$];

  // Model of q right after the newest edge in h.
  // A reset in any of the last S edges means the output is the reset value.
  // Otherwise q is the d sampled S-1 edges ago.
  // With fewer than S edges of history, q is still unknown.
  function automatic exp_t model(input logic [8:0] h[$], input int s, input logic [7:0] rv);
    exp_t e;
    e.known = 1'b0;
    e.val = 8'h00;
    for (int k = 0; k < s; k++) begin
      if (k >= h.size()) return e;
      if (h[h.size()-1-k][8]) begin
        e.known = 1'b1;
        e.val = rv;
        return e;
      end
    end
    e.known = 1'b1;
    e.val = h[h.size()-s][7:0];
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus side: record the inputs seen at each edge and queue the expected q.
  always @(posedge clk) begin
    h1.push_back({rst1, 7'd0, d1});
    h8.push_back({rst8, d8});
    sb1.push_back(model(h1, 1, 8'h00));
    sb8.push_back(model(h8, 3, 8'hA5));
  end

  // Monitor: compare q shortly after every edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb1.size() != 0) begin
      e = sb1.pop_front();
      if (e.known) begin
        known1++;
        check("q_default", {7'd0, q1}, e.val);
      end
    end
    if (sb8.size() != 0) begin
      e = sb8.pop_front();
      if (e.known) begin
        known8++;
        check("q_w8s3", q8, e.val);
      end
    end
  end

  task automatic drive1(input logic r, input logic v);
    @(negedge clk);
    rst1 = r;
    d1 = v;
  endtask

  task automatic drive8(input logic r, input logic [7:0] v);
    @(negedge clk);
    rst8 = r;
    d8 = v;
  endtask

  initial begin
    fork
      begin : default_cfg
        // Power-up: rst=0 and d=0 before the first edge.
        // The monitor expects q=0 after that edge.
        @(posedge clk);

        // Tracking.
        drive1(0, 0); drive1(0, 1); drive1(0, 0); drive1(0, 1);

        // Reset priority, with d held high and then toggled under reset.
        drive1(1, 1); drive1(1, 0); drive1(1, 1);

        // Release with d=1.
        drive1(0, 1); drive1(0, 1);

        // Mid-cycle rst must not affect q before the edge.
        @(negedge clk);
        #2 rst1 = 1'b1;
        #1 check("async_rst", {7'd0, q1}, 8'h01);

        // Toggle d between edges; only the value at the edge counts.
        @(negedge clk);
        rst1 = 1'b0;
        d1 = 1'b1;
        #1 d1 = 1'b0;
        #1 d1 = 1'b1;
        #1 d1 = 1'b0;
        check("async_d", {7'd0, q1}, 8'h00);

        repeat (300) drive1(($urandom % 10) == 0, 1'($urandom));
      end

      begin : param_cfg
        drive8(1, 8'h00);
        drive8(0, 8'h01); drive8(0, 8'h02); drive8(0, 8'h03);
        drive8(0, 8'h04); drive8(0, 8'h05);

        // Mid-stream reset.
        drive8(1, 8'h06);
        drive8(0, 8'h07); drive8(0, 8'h08); drive8(0, 8'h09); drive8(0, 8'h0A);

        repeat (300) drive8(($urandom % 12) == 0, 8'($urandom));
      end
    join

    repeat (4) @(negedge clk);
    check("coverage_default", 8'(known1 > 250), 8'h01);
    check("coverage_w8s3", 8'(known8 > 250), 8'h01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
